// File: rtl/svo_tmds_dec.sv
// svo_tmds_dec: TMDS symbol decoder for loopback capture of the video output path.
// Turns three word-aligned 10-bit TMDS channels back into 24-bit RGB AXI-stream
// pixels, recovers frame boundaries from VSYNC control tokens, and buffers the
// result in a first-word-fall-through FIFO that rides out short tready stalls.
module svo_tmds_dec #(
    parameter int FIFO_DEPTH  = 16,
    parameter bit VSYNC_POL   = 1'b1,
    parameter int ERRCNT_BITS = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   in_valid,
    input  logic [9:0]             in_tmds_d0,
    input  logic [9:0]             in_tmds_d1,
    input  logic [9:0]             in_tmds_d2,
    output logic                   out_axis_tvalid,
    input  logic                   out_axis_tready,
    output logic [23:0]            out_axis_tdata,
    output logic                   out_axis_tuser,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   frame_lock,
    output logic                   err_overflow,
    output logic [ERRCNT_BITS-1:0] err_count,
    input  logic                   err_clear
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    // The four TMDS control tokens, named by the {c1,c0} pair they carry.
    localparam logic [9:0] TOK_C00 = 10'h354;
    localparam logic [9:0] TOK_C01 = 10'h0AB;
    localparam logic [9:0] TOK_C10 = 10'h154;
    localparam logic [9:0] TOK_C11 = 10'h2AB;

    function automatic logic is_ctrl_tok(input logic [9:0] sym);
        return (sym == TOK_C00) || (sym == TOK_C01) ||
               (sym == TOK_C10) || (sym == TOK_C11);
    endfunction

    // {c1,c0} carried by a control token; only meaningful when is_ctrl_tok is true.
    function automatic logic [1:0] ctrl_code(input logic [9:0] sym);
        logic [1:0] c;
        case (sym)
            TOK_C01: c = 2'b01;
            TOK_C10: c = 2'b10;
            TOK_C11: c = 2'b11;
            default: c = 2'b00;
        endcase
        return c;
    endfunction

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8 selects XOR).
    function automatic logic [7:0] tmds_decode(input logic [9:0] sym);
        logic [7:0] dp;
        logic [7:0] q;
        dp   = sym[9] ? ~sym[7:0] : sym[7:0];
        q[0] = dp[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = sym[8] ? (dp[i] ^ dp[i-1]) : ~(dp[i] ^ dp[i-1]);
        end
        return q;
    endfunction

    // Error counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERRCNT_BITS-1:0] sat_inc(input logic [ERRCNT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    typedef enum logic [1:0] {
        SEARCH,
        SYNC,
        ACTIVE
    } state_t;

    // ---- Stage 0: classify the incoming symbol triple and decode the bytes ----
    logic        tok0, tok1, tok2;
    logic        ctrl_p0, data_p0, mixed_p0;
    logic [1:0]  c_p0;
    logic [23:0] pix_p0;

    // Combinational classification and decode of the current input symbols.
    always_comb begin
        tok0     = is_ctrl_tok(in_tmds_d0);
        tok1     = is_ctrl_tok(in_tmds_d1);
        tok2     = is_ctrl_tok(in_tmds_d2);
        ctrl_p0  = tok0 & tok1 & tok2;
        data_p0  = ~(tok0 | tok1 | tok2);
        mixed_p0 = ~ctrl_p0 & ~data_p0;
        c_p0     = ctrl_code(in_tmds_d0);
        // Blue rides on channel 0 and lands in the top byte; red on channel 2, bottom byte.
        pix_p0   = {tmds_decode(in_tmds_d0), tmds_decode(in_tmds_d1), tmds_decode(in_tmds_d2)};
    end

    // ---- Stage 1: registered classification and decoded pixel ----
    logic        vld_p1;
    logic        ctrl_p1;
    logic        data_p1;
    logic        vs_tok_p1;
    logic [23:0] pix_p1;

    // Control side of stage 1: valid and symbol class for the frame FSM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1    <= 1'b0;
            ctrl_p1   <= 1'b0;
            data_p1   <= 1'b0;
            vs_tok_p1 <= 1'b0;
        end else begin
            vld_p1    <= in_valid;
            ctrl_p1   <= ctrl_p0;
            data_p1   <= data_p0;
            vs_tok_p1 <= (c_p0[1] == VSYNC_POL);
        end
    end

    // Data side of stage 1: decoded pixel, qualified downstream by vld_p1/data_p1.
    always_ff @(posedge clk) begin
        pix_p1 <= pix_p0;
    end

    // Sync outputs follow channel 0's control bits, updated only in control periods.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else if (in_valid && ctrl_p0) begin
            hsync <= c_p0[0];
            vsync <= c_p0[1];
        end
    end

    // Mixed control/data symbol counter; a clear in the same cycle beats a new error.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_count <= '0;
        end else if (err_clear) begin
            err_count <= '0;
        end else if (in_valid && mixed_p0) begin
            err_count <= sat_inc(err_count);
        end
    end

    // ---- Stage 2: frame FSM and FIFO write ----
    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic [24:0]   mem [FIFO_DEPTH];
    logic          fifo_full;
    logic          pop;
    logic          mixed_p1;
    logic          emit;
    logic          push;
    logic          drop;

    // Push/drop decision; a pop in the same cycle frees the slot a full FIFO needs.
    always_comb begin
        fifo_full = (fifo_cnt == FULL_CNT);
        pop       = out_axis_tvalid & out_axis_tready;
        mixed_p1  = ~ctrl_p1 & ~data_p1;
        emit      = vld_p1 & data_p1 & (state != SEARCH);
        push      = emit & (~fifo_full | pop);
        drop      = emit & fifo_full & ~pop;
    end

    // Frame FSM plus the sticky overflow flag; a dropped pixel forces a resync.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= SEARCH;
            err_overflow <= 1'b0;
        end else begin
            if (vld_p1) begin
                if (mixed_p1) begin
                    state <= SEARCH;
                end else if (ctrl_p1) begin
                    // vsync from any state (re)arms the SOF; hblank leaves the state alone.
                    if (vs_tok_p1) begin
                        state <= SYNC;
                    end
                end else if (state != SEARCH) begin
                    state <= drop ? SEARCH : ACTIVE;
                end
            end
            if (err_clear) begin
                err_overflow <= 1'b0;
            end else if (drop) begin
                err_overflow <= 1'b1;
            end
        end
    end

    assign frame_lock = (state != SEARCH);

    // FIFO storage; the SOF flag is the pixel pushed while still in SYNC.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {(state == SYNC), pix_p1};
        end
    end

    // FIFO pointers and occupancy; reset empties the FIFO at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ---- Output: first-word-fall-through head of the FIFO ----
    assign out_axis_tvalid = (fifo_cnt != '0);
    assign out_axis_tdata  = out_axis_tvalid ? mem[rd_ptr][23:0] : 24'h000000;
    assign out_axis_tuser  = out_axis_tvalid & mem[rd_ptr][24];

endmodule
